// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: decodes memory ops, runs a stalling bus handshake with timeout
// and misalignment error reporting, and forwards EX/MEM results to MEM/WB.
module mem_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  output logic        stallreq,
  output logic        bus_err_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic [7:0]    op_q;
  logic [1:0]    off_q;
  logic          tmo_q;
  logic          tmo_pulse;
  logic          mis_held;

  logic          is_load;
  logic          is_store;
  logic          is_mem;
  logic [1:0]    size;      // 0 byte, 1 half, 2 word
  logic          misaligned;
  logic          go;
  logic [3:0]    sel_c;
  logic [31:0]   wdata_c;

  function automatic logic op_is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  // Big-endian lane pick: offset 0 is the most significant byte.
  function automatic logic [31:0] load_ext(input logic [7:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'd0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = 2'd0;
    case (aluop_i)
      OP_LB, OP_LBU: begin is_load  = 1'b1; size = 2'd0; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; size = 2'd1; end
      OP_LW:         begin is_load  = 1'b1; size = 2'd2; end
      OP_SB:         begin is_store = 1'b1; size = 2'd0; end
      OP_SH:         begin is_store = 1'b1; size = 2'd1; end
      OP_SW:         begin is_store = 1'b1; size = 2'd2; end
      default:       ;
    endcase
    is_mem     = is_load | is_store;
    misaligned = is_mem && (((size == 2'd1) && mem_addr_i[0]) ||
                            ((size == 2'd2) && (mem_addr_i[1:0] != 2'b00)));
    go         = is_mem && !misaligned;

    case (size)
      2'd0:    sel_c = 4'b1000 >> mem_addr_i[1:0];
      2'd1:    sel_c = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      default: sel_c = 4'b1111;
    endcase
    case (size)
      2'd0:    wdata_c = {4{reg2_i[7:0]}};
      2'd1:    wdata_c = {2{reg2_i[15:0]}};
      default: wdata_c = reg2_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      op_q      <= '0;
      off_q     <= '0;
      tmo_q     <= 1'b0;
      tmo_pulse <= 1'b0;
      mis_held  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo_pulse <= 1'b0;
          // A misaligned op parked by a MEM/WB hold reports its error only once.
          mis_held  <= misaligned && stall[4];
          if (go) begin
            state   <= ACCESS;
            cnt     <= '0;
            addr_q  <= {mem_addr_i[31:2], 2'b00};
            sel_q   <= sel_c;
            we_q    <= is_store;
            wdata_q <= is_store ? wdata_c : 32'd0;
            op_q    <= aluop_i;
            off_q   <= mem_addr_i[1:0];
            rdata_q <= '0;
            tmo_q   <= 1'b0;
          end
        end
        ACCESS: begin
          if (dbus_ack) begin
            rdata_q <= dbus_rdata;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            rdata_q   <= '0;
            tmo_q     <= 1'b1;
            tmo_pulse <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          tmo_pulse <= 1'b0;
          mis_held  <= 1'b0;
          if (!stall[4]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = '0;
    dbus_sel   = '0;
    dbus_wdata = '0;
    stallreq   = 1'b0;
    bus_err_o  = 1'b0;
    if (!rst) begin
      wd_o      = wd_i;
      wreg_o    = wreg_i;
      wdata_o   = wdata_i;
      whilo_o   = whilo_i;
      hi_o      = hi_i;
      lo_o      = lo_i;
      bus_err_o = tmo_pulse | ((state == IDLE) && misaligned && !mis_held);
      case (state)
        IDLE: begin
          if (is_mem) wreg_o = 1'b0;
          stallreq = go;
        end
        ACCESS: begin
          wreg_o     = 1'b0;
          stallreq   = 1'b1;
          dbus_req   = 1'b1;
          dbus_we    = we_q;
          dbus_addr  = addr_q;
          dbus_sel   = sel_q;
          dbus_wdata = wdata_q;
        end
        DONE: begin
          wreg_o = tmo_q ? 1'b0 : wreg_i;
          if (op_is_load(op_q)) wdata_o = load_ext(op_q, off_q, rdata_q);
        end
        default: ;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{stall[5], stall[3:0]};

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles waiting for dbus_ack.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall  in  6  pipeline stall vector; bit 4 = MEM/WB hold.
REQ-005 wd_i  in  5  destination register from EX/MEM.
REQ-006 wreg_i  in  1  register write enable from EX/MEM.
REQ-007 wdata_i  in  32  ALU result from EX/MEM.
REQ-008 whilo_i  in  1  HI/LO write enable.
REQ-009 hi_i  in  32  HI value.
REQ-010 lo_i  in  32  LO value.
REQ-011 aluop_i  in  8  operation code.
REQ-012 mem_addr_i  in  32  effective byte address.
REQ-013 reg2_i  in  32  store source data.
REQ-014 dbus_rdata  in  32  read data, valid when dbus_ack=1.
REQ-015 dbus_ack  in  1  bus completion.
REQ-016 wd_o  out  5  to MEM/WB.
REQ-017 wreg_o  out  1  to MEM/WB.
REQ-018 wdata_o  out  32  to MEM/WB.
REQ-019 whilo_o  out  1  to MEM/WB.
REQ-020 hi_o  out  32  to MEM/WB.
REQ-021 lo_o  out  32  to MEM/WB.
REQ-022 dbus_req  out  1  bus request.
REQ-023 dbus_we  out  1  1=store.
REQ-024 dbus_addr  out  32  {mem_addr_i[31:2],2'b00}.
REQ-025 dbus_sel  out  4  byte lanes, big-endian (sel[3]=addr 00).
REQ-026 dbus_wdata  out  32  store data.
REQ-027 stallreq  out  1  stall request to pipeline control.
REQ-028 bus_err_o  out  1  one-cycle pulse on timeout or misalignment.

Function
REQ-029 Memory ops: LB E0, LH E1, LW E3, LBU E4, LHU E5, SB E8, SH E9, SW EB (hex); all else non-memory.
REQ-030 Non-memory op: outputs = inputs combinationally, stallreq=0, no bus activity.
REQ-031 FSM states IDLE, ACCESS, DONE; IDLE + memory op -> stallreq=1, next ACCESS.
REQ-032 ACCESS: dbus_req=1, stallreq=1, bus fields held stable; dbus_ack=1 -> capture rdata, next DONE.
REQ-033 DONE: stallreq=0, result presented; next IDLE when stall[4]=0, else remain DONE.
REQ-034 Timeout counter cleared entering ACCESS; reaching TIMEOUT without ack -> DONE with captured data 0, wreg_o=0, bus_err_o pulse.
REQ-035 Minimum load/store latency: 3 cycles (IDLE, ACCESS with ack, DONE).
REQ-036 Sel: byte 00->1000, 01->0100, 10->0010, 11->0001; half 00->1100, 10->0011; word 1111.
REQ-037 Store data: SB {4{reg2_i[7:0]}}, SH {2{reg2_i[15:0]}}, SW reg2_i.
REQ-038 Load data: selected lane(s); LB/LH sign-extended, LBU/LHU zero-extended, LW whole word.
REQ-039 Misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0): no bus access, wreg_o=0, bus_err_o pulse, stallreq=0.
REQ-040 Stores: wreg_o=wreg_i, wdata_o=wdata_i in DONE; whilo/hi/lo always pass through.
REQ-041 Outside DONE, memory op outputs wreg_o=0 (bubble via stall).

Reset
REQ-042 rst=1: state IDLE, counter 0, captured data 0, all outputs 0, mid-ACCESS abandons request next cycle.

Verification
REQ-043 LB addr 0x103, rdata 0x000000F0, ack 2nd ACCESS cycle -> wdata_o 0xFFFFFFF0, sel 0001, stallreq high 3 cycles.
REQ-044 SH addr 0x202, reg2 0x1234ABCD -> dbus_we=1, sel 0011, wdata 0xABCDABCD.
REQ-045 LW addr 0x101 -> no dbus_req, bus_err_o 1 cycle, wreg_o=0.
REQ-046 LW, ack never, TIMEOUT=4 -> DONE after 4 ACCESS cycles, wreg_o=0, bus_err_o pulse.
REQ-047 DONE with stall[4]=1 for 2 cycles -> result held, state stays DONE, then IDLE.
REQ-048 rst asserted mid-ACCESS -> dbus_req=0 next cycle, all outputs 0.
